// File: rtl/pll_drp_seq.sv
// PLL dynamic-reconfiguration sequencer: read-modify-write of up to 8 DRP registers with PLL held in reset.
// Optional DRDY watchdog enabled by defining PLL_DRP_SEQ_TIMEOUT_EN.
module pll_drp_seq #(
    parameter int DRDY_TIMEOUT = 64,
    parameter int RST_HOLD     = 4
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        START,
    input  logic        CFG_WE,
    input  logic [2:0]  CFG_IDX,
    input  logic [6:0]  CFG_ADDR,
    input  logic [15:0] CFG_MASK,
    input  logic [15:0] CFG_VALUE,
    input  logic [3:0]  CFG_COUNT,
    output logic [6:0]  DADDR,
    output logic        DEN,
    output logic        DWE,
    output logic [15:0] DI,
    input  logic [15:0] DO,
    input  logic        DRDY,
    output logic        PLL_RST,
    input  logic        LOCKED,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR
);

    if (DRDY_TIMEOUT < 4 || DRDY_TIMEOUT > 1023) begin : g_bad_timeout
        $error("pll_drp_seq: DRDY_TIMEOUT must be 4..1023");
    end
    if (RST_HOLD < 1 || RST_HOLD > 255) begin : g_bad_hold
        $error("pll_drp_seq: RST_HOLD must be 1..255");
    end

    localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        WR_WAIT,
        HOLD,
        LOCK_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  n_q, n_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        den_q, den_d;
    logic        dwe_q, dwe_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] di_q, di_d;
    logic        pll_rst_q, pll_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [6:0]  addr_q  [8];
    logic [6:0]  addr_d  [8];
    logic [15:0] mask_q  [8];
    logic [15:0] mask_d  [8];
    logic [15:0] value_q [8];
    logic [15:0] value_d [8];

    logic [3:0]  cfg_n;

    assign cfg_n = (CFG_COUNT > 4'd8) ? 4'd8 : CFG_COUNT;

    // Configuration table
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            addr_d[i]  = addr_q[i];
            mask_d[i]  = mask_q[i];
            value_d[i] = value_q[i];
        end
        if (CFG_WE && !busy_q) begin
            addr_d[CFG_IDX]  = CFG_ADDR;
            mask_d[CFG_IDX]  = CFG_MASK;
            value_d[CFG_IDX] = CFG_VALUE;
        end
    end

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < 8; i++) begin
                addr_q[i]  <= '0;
                mask_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                addr_q[i]  <= addr_d[i];
                mask_q[i]  <= mask_d[i];
                value_q[i] <= value_d[i];
            end
        end
    end

`ifdef PLL_DRP_SEQ_TIMEOUT_EN
    localparam logic [9:0] WD_LAST = 10'(DRDY_TIMEOUT - 1);

    logic [9:0] wd_q, wd_d;
    logic       error_q, error_d;
    logic       wd_expired;

    // Watchdog restarts whenever the FSM leaves a wait state.
    always_comb begin
        wd_d = '0;
        if (state_q == RD_WAIT || state_q == WR_WAIT) begin
            wd_d = wd_q + 10'd1;
        end
    end

    assign wd_expired = (wd_q == WD_LAST);

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end

    assign ERROR = error_q;
`else
    assign ERROR = 1'b0;
`endif

    // Sequencer next-state and registered outputs. DEN/DWE/DADDR are set on
    // the edge that enters RD/WR so they are valid for the whole access cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        den_d     = 1'b0;
        dwe_d     = 1'b0;
        daddr_d   = daddr_q;
        di_d      = di_q;
        pll_rst_d = pll_rst_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef PLL_DRP_SEQ_TIMEOUT_EN
        error_d   = error_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (START) begin
`ifdef PLL_DRP_SEQ_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                    if (cfg_n != 4'd0) begin
                        n_d       = cfg_n;
                        idx_d     = '0;
                        busy_d    = 1'b1;
                        pll_rst_d = 1'b1;
                        den_d     = 1'b1;
                        daddr_d   = addr_q[0];
                        state_d   = RD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RD: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (DRDY) begin
                    di_d    = (DO & mask_q[idx_q]) | (value_q[idx_q] & ~mask_q[idx_q]);
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    daddr_d = addr_q[idx_q];
                    state_d = WR;
                end
`ifdef PLL_DRP_SEQ_TIMEOUT_EN
                else if (wd_expired) begin
                    error_d   = 1'b1;
                    pll_rst_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
`endif
            end
            WR: begin
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (DRDY) begin
                    if ({1'b0, idx_q} < (n_q - 4'd1)) begin
                        idx_d   = idx_q + 3'd1;
                        den_d   = 1'b1;
                        daddr_d = addr_q[idx_d];
                        state_d = RD;
                    end else begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end
                end
`ifdef PLL_DRP_SEQ_TIMEOUT_EN
                else if (wd_expired) begin
                    error_d   = 1'b1;
                    pll_rst_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
`endif
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                    state_d   = LOCK_WAIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LOCK_WAIT: begin
                // cnt_q == 0 marks the first LOCK_WAIT cycle, where LOCKED may be stale.
                if (cnt_q == 8'd0) begin
                    cnt_d = 8'd1;
                end else if (LOCKED) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            daddr_q   <= '0;
            di_q      <= '0;
            pll_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            den_q     <= den_d;
            dwe_q     <= dwe_d;
            daddr_q   <= daddr_d;
            di_q      <= di_d;
            pll_rst_q <= pll_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign DADDR   = daddr_q;
    assign DEN     = den_q;
    assign DWE     = dwe_q;
    assign DI      = di_q;
    assign PLL_RST = pll_rst_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_pll_drp_seq.sv
// Directed bench for pll_drp_seq with a DRP slave model answering DRDY 2 cycles after each DEN.
// Define PLL_DRP_SEQ_TIMEOUT_EN to exercise the watchdog variant.
module tb_pll_drp_seq;

    logic        DCLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        CFG_WE = 1'b0;
    logic [2:0]  CFG_IDX = '0;
    logic [6:0]  CFG_ADDR = '0;
    logic [15:0] CFG_MASK = '0;
    logic [15:0] CFG_VALUE = '0;
    logic [3:0]  CFG_COUNT = '0;
    logic [6:0]  DADDR;
    logic        DEN;
    logic        DWE;
    logic [15:0] DI;
    logic [15:0] DO = 16'hA0FF;
    logic        DRDY = 1'b0;
    logic        PLL_RST;
    logic        LOCKED = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;

    int tests_run = 0;
    int tests_failed = 0;

    // Slave-model state, written only by the monitor process.
    logic [6:0]  log_addr [$];
    logic        log_we   [$];
    logic [15:0] log_di   [$];
    int          den_cnt = 0;
    int          b2b_cnt = 0;
    int          done_cnt = 0;
    int          rst_after_wr = 0;
    int          rsp_cnt = 0;
    int          drdy_seen = 0;
    logic        prev_den = 1'b0;
    // Written only by the main process.
    bit          drp_auto = 1'b1;
    int          drdy_req = 0;

    pll_drp_seq #(.DRDY_TIMEOUT(64), .RST_HOLD(4)) dut (
        .DCLK(DCLK), .RST(RST), .START(START), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX),
        .CFG_ADDR(CFG_ADDR), .CFG_MASK(CFG_MASK), .CFG_VALUE(CFG_VALUE), .CFG_COUNT(CFG_COUNT),
        .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
        .PLL_RST(PLL_RST), .LOCKED(LOCKED), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
    );

    always #5 DCLK = ~DCLK;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // DRP slave model and activity monitor
    initial begin
        forever begin
            @(negedge DCLK);
            if (DRDY) DRDY = 1'b0;
            if (RST) begin
                rsp_cnt = 0;
            end else if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) DRDY = 1'b1;
            end
            if (drdy_req != drdy_seen) begin
                DRDY = 1'b1;
                drdy_seen = drdy_req;
            end
            if (DEN) begin
                log_addr.push_back(DADDR);
                log_we.push_back(DWE);
                log_di.push_back(DI);
                den_cnt++;
                if (prev_den) b2b_cnt++;
                if (DWE) rst_after_wr = 0;
                if (drp_auto) rsp_cnt = 2;
            end else if (PLL_RST) begin
                rst_after_wr++;
            end
            if (DONE) done_cnt++;
            prev_den = DEN;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge DCLK);
            #1;
        end
    endtask

    task automatic write_entry(input logic [2:0] idx, input logic [6:0] addr,
                               input logic [15:0] mask, input logic [15:0] value);
        CFG_WE = 1'b1; CFG_IDX = idx; CFG_ADDR = addr; CFG_MASK = mask; CFG_VALUE = value;
        cyc(1);
        CFG_WE = 1'b0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        cyc(1);
        START = 1'b0;
    endtask

    task automatic wait_rst_low(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!PLL_RST) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (DONE) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        cyc(2);
        tests_run++;
        if ({DEN, DWE, PLL_RST, BUSY, DONE, ERROR} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b, expected 000000", {DEN, DWE, PLL_RST, BUSY, DONE, ERROR});
        end
        tests_run++;
        if (DADDR !== 7'h00 || DI !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_bus: got DADDR=%h DI=%h, expected 00/0000", DADDR, DI);
        end
        RST = 1'b0;
    endtask

    task automatic test_single();
        int base, dbase;
        bit ok;
        LOCKED = 1'b0;
        DO = 16'hA0FF;
        write_entry(3'd0, 7'h08, 16'hF000, 16'h0145);
        CFG_COUNT = 4'd1;
        base = log_addr.size();
        dbase = done_cnt;
        pulse_start();
        tests_run++;
        if (BUSY !== 1'b1 || PLL_RST !== 1'b1 || DEN !== 1'b1 || DWE !== 1'b0 || DADDR !== 7'h08) begin
            tests_failed++;
            $display("FAIL single_start: got BUSY=%b PLL_RST=%b DEN=%b DWE=%b DADDR=%h, expected 1 1 1 0 08",
                     BUSY, PLL_RST, DEN, DWE, DADDR);
        end
        wait_rst_low(200, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL single_rst_release: PLL_RST still %b after 200 cycles, expected 0", PLL_RST);
        end
        tests_run++;
        if (rst_after_wr != 6) begin
            tests_failed++;
            $display("FAIL single_rst_hold: got %0d PLL_RST cycles after write, expected 6", rst_after_wr);
        end
        cyc(3);
        tests_run++;
        if (DONE !== 1'b0 || BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_wait_lock: got DONE=%b BUSY=%b, expected 0 1", DONE, BUSY);
        end
        LOCKED = 1'b1;
        cyc(1);
        tests_run++;
        if (DONE !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_done: got DONE=%b one cycle after LOCKED, expected 1", DONE);
        end
        cyc(1);
        tests_run++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_end: got DONE=%b BUSY=%b, expected 0 0", DONE, BUSY);
        end
        tests_run++;
        if (log_addr.size() - base != 2 || log_addr[base] !== 7'h08 || log_we[base] !== 1'b0 ||
            log_addr[base+1] !== 7'h08 || log_we[base+1] !== 1'b1 || log_di[base+1] !== 16'hA145) begin
            tests_failed++;
            $display("FAIL single_traffic: got %0d accesses, expected R08 then W08 DI=a145", log_addr.size() - base);
        end
        tests_run++;
        if (done_cnt - dbase != 1) begin
            tests_failed++;
            $display("FAIL single_done_count: got %0d, expected 1", done_cnt - dbase);
        end
        LOCKED = 1'b0;
    endtask

    task automatic test_multi();
        int base, dbase, bbase;
        bit ok;
        logic [6:0]  exp_addr [6] = '{7'h08, 7'h08, 7'h09, 7'h09, 7'h14, 7'h14};
        logic        exp_we   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] exp_di   [3] = '{16'hA145, 16'h12FF, 16'hBEEF};
        write_entry(3'd0, 7'h08, 16'hF000, 16'h0145);
        write_entry(3'd1, 7'h09, 16'h00FF, 16'h1234);
        write_entry(3'd2, 7'h14, 16'h0000, 16'hBEEF);
        CFG_COUNT = 4'd3;
        LOCKED = 1'b1;
        base = log_addr.size();
        dbase = done_cnt;
        bbase = b2b_cnt;
        pulse_start();
        wait_rst_low(300, ok);
        tests_run++;
        if (!ok || DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL multi_lock_first: got ok=%b DONE=%b at PLL_RST fall, expected 1 0", ok, DONE);
        end
        cyc(1);
        tests_run++;
        if (DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL multi_lock_ignore: got DONE=%b in first LOCK_WAIT cycle, expected 0", DONE);
        end
        cyc(1);
        tests_run++;
        if (DONE !== 1'b1) begin
            tests_failed++;
            $display("FAIL multi_done: got DONE=%b, expected 1", DONE);
        end
        tests_run++;
        if (log_addr.size() - base != 6 || b2b_cnt != bbase) begin
            tests_failed++;
            $display("FAIL multi_den_count: got %0d DEN pulses, %0d back-to-back, expected 6 and 0",
                     log_addr.size() - base, b2b_cnt - bbase);
        end else begin
            for (int k = 0; k < 6; k++) begin
                tests_run++;
                if (log_addr[base+k] !== exp_addr[k] || log_we[base+k] !== exp_we[k] ||
                    (exp_we[k] && log_di[base+k] !== exp_di[k/2])) begin
                    tests_failed++;
                    $display("FAIL multi_access%0d: got addr=%h we=%b di=%h, expected addr=%h we=%b di=%h",
                             k, log_addr[base+k], log_we[base+k], log_di[base+k], exp_addr[k], exp_we[k], exp_di[k/2]);
                end
            end
        end
        cyc(2);
        tests_run++;
        if (DADDR !== 7'h14 || DI !== 16'hBEEF || DEN !== 1'b0) begin
            tests_failed++;
            $display("FAIL multi_bus_hold: got DADDR=%h DI=%h DEN=%b, expected 14 beef 0", DADDR, DI, DEN);
        end
        tests_run++;
        if (done_cnt - dbase != 1) begin
            tests_failed++;
            $display("FAIL multi_done_count: got %0d, expected 1", done_cnt - dbase);
        end
    endtask

    task automatic test_count_clamp();
        int base;
        bit ok;
        for (int k = 0; k < 8; k++) begin
            write_entry(3'(k), 7'(7'h20 + k), 16'hFFFF, 16'h0000);
        end
        CFG_COUNT = 4'hF;
        LOCKED = 1'b1;
        base = log_addr.size();
        pulse_start();
        wait_done(500, ok);
        tests_run++;
        if (!ok || log_addr.size() - base != 16) begin
            tests_failed++;
            $display("FAIL clamp_count: got done=%b accesses=%0d, expected 1 and 16", ok, log_addr.size() - base);
        end else begin
            tests_run++;
            if (log_addr[base+15] !== 7'h27 || log_we[base+15] !== 1'b1 || log_di[base+15] !== 16'hA0FF) begin
                tests_failed++;
                $display("FAIL clamp_last: got addr=%h we=%b di=%h, expected 27 1 a0ff",
                         log_addr[base+15], log_we[base+15], log_di[base+15]);
            end
        end
        cyc(2);
    endtask

    task automatic test_zero();
        int dbase, denbase;
        CFG_COUNT = 4'd0;
        dbase = done_cnt;
        denbase = den_cnt;
        pulse_start();
        tests_run++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || PLL_RST !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done: got DONE=%b BUSY=%b PLL_RST=%b, expected 1 0 0", DONE, BUSY, PLL_RST);
        end
        cyc(1);
        tests_run++;
        if (DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_pulse_width: got DONE=%b, expected 0", DONE);
        end
        cyc(5);
        tests_run++;
        if (den_cnt != denbase || done_cnt - dbase != 1 || PLL_RST !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_quiet: got %0d DEN, %0d DONE, PLL_RST=%b, expected 0 1 0",
                     den_cnt - denbase, done_cnt - dbase, PLL_RST);
        end
    endtask

    task automatic test_busy_ignore();
        int base, dbase;
        bit ok;
        LOCKED = 1'b0;
        write_entry(3'd0, 7'h10, 16'h0000, 16'h1111);
        write_entry(3'd1, 7'h11, 16'h0000, 16'h2222);
        CFG_COUNT = 4'd2;
        base = log_addr.size();
        dbase = done_cnt;
        pulse_start();
        START = 1'b1; CFG_WE = 1'b1; CFG_IDX = 3'd0; CFG_ADDR = 7'h7F; CFG_MASK = 16'h0000; CFG_VALUE = 16'hDEAD;
        cyc(6);
        START = 1'b0; CFG_WE = 1'b0;
        wait_rst_low(300, ok);
        LOCKED = 1'b1;
        wait_done(20, ok);
        cyc(4);
        tests_run++;
        if (!ok || done_cnt - dbase != 1 || log_addr.size() - base != 4) begin
            tests_failed++;
            $display("FAIL busy_single_run: got done=%0d accesses=%0d, expected 1 and 4",
                     done_cnt - dbase, log_addr.size() - base);
        end else begin
            tests_run++;
            if (log_addr[base] !== 7'h10 || log_di[base+1] !== 16'h1111 || log_addr[base+2] !== 7'h11) begin
                tests_failed++;
                $display("FAIL busy_traffic: got %h/%h/%h, expected 10/1111/11",
                         log_addr[base], log_di[base+1], log_addr[base+2]);
            end
        end
        CFG_COUNT = 4'd1;
        base = log_addr.size();
        pulse_start();
        wait_done(200, ok);
        tests_run++;
        if (!ok || log_addr.size() - base != 2 || log_addr[base] !== 7'h10 || log_di[base+1] !== 16'h1111) begin
            tests_failed++;
            $display("FAIL busy_table_kept: got done=%b accesses=%0d, expected entry0 still 10/1111",
                     ok, log_addr.size() - base);
        end
        LOCKED = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset_mid();
        int base, snap;
        bit ok, found;
        write_entry(3'd0, 7'h30, 16'hFFFF, 16'h0000);
        write_entry(3'd1, 7'h31, 16'hFFFF, 16'h0000);
        CFG_COUNT = 4'd2;
        LOCKED = 1'b0;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (DEN && DWE) begin
                found = 1'b1;
                break;
            end
            cyc(1);
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL rstmid_write_seen: no DRP write within 20 cycles, expected one");
        end
        cyc(1);
        RST = 1'b1;
        #1;
        tests_run++;
        if (PLL_RST !== 1'b0 || BUSY !== 1'b0 || DEN !== 1'b0 || DADDR !== 7'h00 || DI !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rstmid_async: got PLL_RST=%b BUSY=%b DEN=%b DADDR=%h DI=%h, expected 0 0 0 00 0000",
                     PLL_RST, BUSY, DEN, DADDR, DI);
        end
        cyc(3);
        RST = 1'b0;
        snap = log_addr.size();
        write_entry(3'd0, 7'h30, 16'hFFFF, 16'h0000);
        write_entry(3'd1, 7'h31, 16'hFFFF, 16'h0000);
        cyc(3);
        tests_run++;
        if (log_addr.size() != snap || PLL_RST !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_no_partial: got %0d accesses PLL_RST=%b after release, expected 0 0",
                     log_addr.size() - snap, PLL_RST);
        end
        LOCKED = 1'b1;
        base = log_addr.size();
        pulse_start();
        wait_done(300, ok);
        tests_run++;
        if (!ok || log_addr.size() - base != 4 || log_addr[base+3] !== 7'h31 || log_di[base+3] !== 16'hA0FF) begin
            tests_failed++;
            $display("FAIL rstmid_rerun: got done=%b accesses=%0d, expected 1 and 4 ending W31=a0ff",
                     ok, log_addr.size() - base);
        end
        cyc(2);
    endtask

    task automatic test_no_drdy();
        int dbase;
        bit ok;
        write_entry(3'd0, 7'h40, 16'h0000, 16'h5555);
        CFG_COUNT = 4'd1;
        LOCKED = 1'b0;
        drp_auto = 1'b0;
        dbase = done_cnt;
        pulse_start();
        tests_run++;
        if (DEN !== 1'b1) begin
            tests_failed++;
            $display("FAIL nodrdy_den: got DEN=%b, expected 1", DEN);
        end
`ifdef PLL_DRP_SEQ_TIMEOUT_EN
        cyc(64);
        tests_run++;
        if (ERROR !== 1'b0 || BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_early: got ERROR=%b BUSY=%b, expected 0 1", ERROR, BUSY);
        end
        cyc(1);
        tests_run++;
        if (ERROR !== 1'b1 || BUSY !== 1'b0 || PLL_RST !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_expire: got ERROR=%b BUSY=%b PLL_RST=%b, expected 1 0 0", ERROR, BUSY, PLL_RST);
        end
        cyc(10);
        tests_run++;
        if (ERROR !== 1'b1 || done_cnt != dbase) begin
            tests_failed++;
            $display("FAIL wd_sticky: got ERROR=%b DONE count=%0d, expected 1 0", ERROR, done_cnt - dbase);
        end
        drp_auto = 1'b1;
        LOCKED = 1'b1;
        pulse_start();
        tests_run++;
        if (ERROR !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_clear: got ERROR=%b after START, expected 0", ERROR);
        end
        wait_done(200, ok);
`else
        cyc(100);
        tests_run++;
        if (BUSY !== 1'b1 || ERROR !== 1'b0 || DEN !== 1'b0) begin
            tests_failed++;
            $display("FAIL nodrdy_wait: got BUSY=%b ERROR=%b DEN=%b, expected 1 0 0", BUSY, ERROR, DEN);
        end
        drp_auto = 1'b1;
        LOCKED = 1'b1;
        drdy_req++;
        wait_done(200, ok);
`endif
        tests_run++;
        if (!ok || ERROR !== 1'b0) begin
            tests_failed++;
            $display("FAIL nodrdy_recover: got done=%b ERROR=%b, expected 1 0", ok, ERROR);
        end
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_count_clamp();
        test_zero();
        test_busy_ignore();
        test_reset_mid();
        test_no_drdy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pll_drp_seq.md
PLL_DRP_SEQ -- requirements
Module: pll_drp_seq

Interface
REQ-001 SHALL have parameter DRDY_TIMEOUT, default 64, the maximum DCLK cycles to wait for DRDY after DEN (range 4-1023).
REQ-002 SHALL have parameter RST_HOLD, default 4, the minimum DCLK cycles PLL_RST stays high after the final DRP write (range 1-255).
REQ-003 SHALL have the following ports:
- DCLK  in  1  sole clock, rising edge; reset is asynchronous and active-high.
- RST  in  1  asynchronous active-high reset.
- START  in  1  one-cycle request to run the sequence.
- CFG_WE  in  1  table write strobe.
- CFG_IDX  in  3  table entry index.
- CFG_ADDR  in  7  DRP address for the entry.
- CFG_MASK  in  16  bits to keep from the readback (1 = keep).
- CFG_VALUE  in  16  bits to insert where the mask is 0.
- CFG_COUNT  in  4  number of entries to apply, 0-8.
- DADDR  out  7  DRP address.
- DEN  out  1  DRP enable.
- DWE  out  1  DRP write enable.
- DI  out  16  DRP write data.
- DO  in  16  DRP read data.
- DRDY  in  1  DRP ready.
- PLL_RST  out  1  PLL reset.
- LOCKED  in  1  PLL lock.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle completion pulse.
- ERROR  out  1  sticky timeout flag.

Function
REQ-004 SHALL hold an 8-entry table {addr[6:0], mask[15:0], value[15:0]}, written on a DCLK edge when CFG_WE=1 and BUSY=0; when BUSY=1, CFG_WE SHALL be ignored.
REQ-005 SHALL use the states IDLE, RD, RD_WAIT, WR, WR_WAIT, HOLD and LOCK_WAIT.
REQ-006 In IDLE, when START=1 and the latched count N=min(CFG_COUNT,8) is greater than 0, the block SHALL, on the next edge:
- set BUSY=1 and PLL_RST=1;
- set the entry index to 0;
- enter RD.
REQ-007 When START=1 with N=0, the block SHALL pulse DONE one cycle later and SHALL generate no DRP traffic and no PLL_RST.
REQ-008 When BUSY=1, START SHALL be ignored.
REQ-009 In RD, the block SHALL drive DEN=1, DWE=0 and DADDR=addr[i] for exactly one cycle, then enter RD_WAIT.
REQ-010 In RD_WAIT, on DRDY=1 the block SHALL capture DI=(DO & mask[i]) | (value[i] & ~mask[i]) and enter WR.
REQ-011 In WR, the block SHALL drive DEN=1, DWE=1, DADDR=addr[i] and DI for exactly one cycle, then enter WR_WAIT.
REQ-012 In WR_WAIT, on DRDY=1:
- if i<N-1, the block SHALL set i=i+1 and enter RD;
- otherwise it SHALL enter HOLD.
REQ-013 DRDY SHALL be ignored outside RD_WAIT and WR_WAIT; a DRDY in the same cycle as DEN SHALL NOT complete that access.
REQ-014 DEN SHALL never be high for two consecutive cycles, and DEN SHALL NOT be asserted while the block waits for DRDY.
REQ-015 HOLD SHALL keep PLL_RST=1 for RST_HOLD cycles; PLL_RST SHALL then go 0 on the transition to LOCK_WAIT.
REQ-016 LOCK_WAIT SHALL ignore LOCKED in its first cycle; on the first later cycle with LOCKED=1, the block SHALL pulse DONE, clear BUSY and return to IDLE.
REQ-017 DADDR and DI SHALL hold their last values when DEN=0; DONE SHALL be high for exactly one cycle per sequence.

Reset
REQ-018 RST=1 SHALL, immediately and without a clock edge:
- force IDLE;
- set DEN, DWE, PLL_RST, BUSY, DONE and ERROR to 0;
- set DADDR to 0 and DI to 0;
- clear all table entries to 0.
REQ-019 RST asserted mid-sequence SHALL abort the sequence, with PLL_RST returning to 0 and no partial write issued after reset release.
REQ-020 After RST deasserts, the first DCLK edge SHALL be able to accept START or CFG_WE.

Configuration
REQ-021 With macro PLL_DRP_SEQ_TIMEOUT_EN defined, a watchdog SHALL count cycles in RD_WAIT and WR_WAIT.
REQ-022 With the watchdog enabled, when DRDY_TIMEOUT cycles elapse without DRDY, the block SHALL:
- set ERROR=1, sticky until RST or the next accepted START;
- deassert PLL_RST;
- clear BUSY;
- return to IDLE without pulsing DONE.
REQ-023 Without PLL_DRP_SEQ_TIMEOUT_EN, the block SHALL wait for DRDY indefinitely, ERROR SHALL be tied to 0, and no watchdog logic SHALL exist.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Entry0 {0x08, 0xF000, 0x0145}, CFG_COUNT=1, DO=0xA0FF, DRDY 2 cycles after each DEN -> one read at 0x08, one write at 0x08 with DI=0xA145, PLL_RST high for at least 4 cycles, DONE one cycle after LOCKED rises.
- CFG_COUNT=3 with entries at addresses 0x08, 0x09, 0x14 -> DRP order R08, W08, R09, W09, R14, W14; exactly six DEN pulses, none back-to-back.
- CFG_COUNT=0, START -> DONE pulse on the next cycle, PLL_RST stays 0, DEN stays 0.
- START and CFG_WE repeated while BUSY=1 -> both ignored, table unchanged, only one DONE.
- RST asserted in WR_WAIT -> PLL_RST, BUSY and DEN go 0 immediately; a new START then runs the full sequence.
- With PLL_DRP_SEQ_TIMEOUT_EN defined, DRDY never returned -> ERROR=1 64 cycles after DEN, BUSY=0, PLL_RST=0, no DONE.
